// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a one-word valid/ready holding register.
// A word that completes while the holding register is full and not draining is dropped and flagged.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             clear,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  m_data_q, m_data_d;
    logic              overrun_q, overrun_d;

    logic              accept;
    logic              complete;
    logic [WIDTH-1:0]  sh_next;

    // sh_next already contains the final bit, so a completing word is loaded from it directly.
    always_comb begin
        accept   = s_valid && !clear;
        sh_next  = MSB_FIRST ? {sh_q[WIDTH-2:0], s_data} : {s_data, sh_q[WIDTH-1:1]};
        complete = accept && (cnt_q == CNT_LAST);
    end

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (s_valid) begin
            sh_d  = sh_next;
            cnt_d = complete ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        overrun_d = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d  = FULL;
                    m_data_d = sh_next;
                end
            end
            FULL: begin
                if (complete) begin
                    if (m_ready) m_data_d  = sh_next;
                    else         overrun_d = 1'b1;
                end else if (m_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            sh_q      <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = (state_q == FULL);
    assign busy    = (cnt_q != '0);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a queue-based word-assembly model.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n, s_valid, s_data, clear, m_ready;
    logic [W-1:0] m_data_m, m_data_l;
    logic m_valid_m, m_valid_l, busy_m, busy_l, ovr_m, ovr_l;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .clear(clear),
        .m_data(m_data_m), .m_valid(m_valid_m), .m_ready(m_ready), .busy(busy_m), .overrun(ovr_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .clear(clear),
        .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready), .busy(busy_l), .overrun(ovr_l)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: bits of the partial word in arrival order, plus the held word.
    bit           part[$];
    logic         exp_valid;
    logic [W-1:0] exp_m, exp_l;
    logic         exp_ovr;

    task automatic model_reset();
        part.delete();
        exp_valid = 1'b0;
        exp_m     = '0;
        exp_l     = '0;
        exp_ovr   = 1'b0;
    endtask

    task automatic model_edge();
        bit           done;
        logic [W-1:0] wm, wl;
        done = 0;
        wm   = '0;
        wl   = '0;
        if (clear) part.delete();
        else if (s_valid) begin
            part.push_back(s_data);
            if (part.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = part[i];
                    wl[i]     = part[i];
                end
                done = 1;
                part.delete();
            end
        end
        exp_ovr = 1'b0;
        if (done) begin
            if (!exp_valid || m_ready) begin
                exp_valid = 1'b1;
                exp_m     = wm;
                exp_l     = wl;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (exp_valid && m_ready) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic compare_all(input string ctx);
        chk({ctx, ":valid_m"}, m_valid_m, exp_valid);
        chk({ctx, ":valid_l"}, m_valid_l, exp_valid);
        chk({ctx, ":busy_m"}, busy_m, part.size() != 0);
        chk({ctx, ":busy_l"}, busy_l, part.size() != 0);
        chk({ctx, ":ovr_m"}, ovr_m, exp_ovr);
        chk({ctx, ":ovr_l"}, ovr_l, exp_ovr);
        if (exp_valid) begin
            chk({ctx, ":data_m"}, m_data_m, exp_m);
            chk({ctx, ":data_l"}, m_data_l, exp_l);
        end
    endtask

    task automatic drive(input logic sv, input logic sd, input logic clr, input logic rdy,
                         input string ctx);
        s_valid = sv;
        s_data  = sd;
        clear   = clr;
        m_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ctx);
    endtask

    task automatic send(input logic [W-1:0] bits_first_to_last, input logic rdy, input string ctx);
        logic [W-1:0] b;
        b = bits_first_to_last;
        for (int i = W - 1; i >= 0; i--) drive(1'b1, b[i], 1'b0, rdy, ctx);
    endtask

    task automatic check_reset_state(input string ctx);
        chk({ctx, ":valid"}, m_valid_m, 1'b0);
        chk({ctx, ":busy"}, busy_m, 1'b0);
        chk({ctx, ":data"}, m_data_m, '0);
        chk({ctx, ":ovr"}, ovr_m, 1'b0);
        chk({ctx, ":data_l"}, m_data_l, '0);
        chk({ctx, ":valid_l"}, m_valid_l, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 1'b0;
        clear   = 1'b0;
        m_ready = 1'b0;
        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bring-up and bit order
        send(4'b1010, 1'b1, "bringup");
        chk("bringup_msb_word", m_data_m, 4'b1010);
        chk("bringup_lsb_word", m_data_l, 4'b0101);
        drive(1'b0, 1'b0, 1'b0, 1'b1, "bringup_drain");

        // Backpressure and overrun
        send(4'b1100, 1'b0, "bp_w1");
        send(4'b0011, 1'b0, "bp_w2");
        chk("overrun_pulse", ovr_m, 1'b1);
        chk("overrun_hold_word", m_data_m, 4'b1100);
        drive(1'b0, 1'b0, 1'b0, 1'b0, "bp_after");
        drive(1'b0, 1'b0, 1'b0, 1'b1, "bp_xfer");
        chk("bp_empty", m_valid_m, 1'b0);

        // Transfer and completion on the same edge
        send(4'b1010, 1'b0, "sim_w1");
        drive(1'b1, 1'b0, 1'b0, 1'b0, "sim_b");
        drive(1'b1, 1'b1, 1'b0, 1'b0, "sim_b");
        drive(1'b1, 1'b1, 1'b0, 1'b0, "sim_b");
        drive(1'b1, 1'b0, 1'b0, 1'b1, "sim_last");
        chk("sim_word", m_data_m, 4'b0110);
        chk("sim_valid", m_valid_m, 1'b1);
        chk("sim_no_ovr", ovr_m, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, "sim_drain");

        // clear beats a simultaneous bit
        drive(1'b1, 1'b1, 1'b0, 1'b1, "clr_pre");
        drive(1'b1, 1'b0, 1'b0, 1'b1, "clr_pre");
        drive(1'b1, 1'b1, 1'b1, 1'b1, "clr");
        chk("clr_busy", busy_m, 1'b0);
        send(4'b1101, 1'b1, "clr_word");
        chk("clr_word_msb", m_data_m, 4'b1101);
        drive(1'b0, 1'b0, 1'b0, 1'b1, "clr_drain");

        // Asynchronous reset mid-word with a word held
        send(4'b0111, 1'b0, "rst_hold");
        drive(1'b1, 1'b1, 1'b0, 1'b0, "rst_part");
        drive(1'b1, 1'b1, 1'b0, 1'b0, "rst_part");
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(4'b1001, 1'b1, "post_rst");
        chk("post_rst_word", m_data_m, 4'b1001);
        drive(1'b0, 1'b0, 1'b0, 1'b1, "post_rst_drain");

        // Gaps between bits
        begin
            logic [W-1:0] g;
            g = 4'b1011;
            for (int i = W - 1; i >= 0; i--) begin
                drive(1'b1, g[i], 1'b0, 1'b0, "gap_bit");
                if (i != 0)
                    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, 1'b0, "gap_idle");
            end
            chk("gap_word", m_data_m, 4'b1011);
            drive(1'b0, 1'b0, 1'b0, 1'b1, "gap_drain");
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0,
                  ($urandom % 3) != 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
